// File: rtl/ldst_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : ldst_cmd_sched
// Purpose  : Command FIFO and issuer in front of the RF load/store engine;
//            splits long transfers into engine-sized chunks, drops empty ones.
// Options  : LDST_SCHED_PERF_EN adds saturating perf_lines/perf_busy_cycles.
// Revision : 1.0 - initial release
// ============================================================================
module ldst_cmd_sched #(
    parameter int RF_ADDR_W   = 10,
    parameter int LINE_NUM_W  = 11,
    parameter int CMD_LINES_W = 16,
    parameter int DEPTH       = 4,
    parameter int LINE_BYTES  = 176
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_op,
    input  logic [31:0]             cmd_sdram_addr,
    input  logic [RF_ADDR_W-1:0]    cmd_rf_addr,
    input  logic [CMD_LINES_W-1:0]  cmd_line_num,
    output logic                    ldst_load_start,
    output logic                    ldst_store_start,
    output logic [31:0]             ldst_sdram_addr,
    output logic [RF_ADDR_W-1:0]    ldst_rf_addr,
    output logic [LINE_NUM_W-1:0]   ldst_line_num,
    input  logic                    ldst_done,
    output logic                    busy,
    output logic                    err_zero_len,
`ifdef LDST_SCHED_PERF_EN
    output logic [31:0]             perf_lines,
    output logic [31:0]             perf_busy_cycles,
`endif
    output logic [$clog2(DEPTH):0]  q_count
);

    localparam int C_PTR_W   = $clog2(DEPTH);
    localparam int C_ENTRY_W = 1 + 32 + RF_ADDR_W + CMD_LINES_W;
    localparam logic [CMD_LINES_W-1:0] C_MAX_CHUNK = CMD_LINES_W'((1 << LINE_NUM_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [C_PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [C_PTR_W:0]        count_q, count_d;
    logic                    op_q, op_d;
    logic [31:0]             saddr_q, saddr_d;
    logic [RF_ADDR_W-1:0]    raddr_q, raddr_d;
    logic [CMD_LINES_W-1:0]  rem_q, rem_d;
    logic                    err_q, err_d;
    logic [C_ENTRY_W-1:0]    mem_q [DEPTH];

    logic                    w_full;
    logic                    w_push;
    logic                    w_push_ok;
    logic                    w_pop;
    logic                    w_start;
    logic [CMD_LINES_W-1:0]  w_chunk;
    logic                    w_head_op;
    logic [31:0]             w_head_saddr;
    logic [RF_ADDR_W-1:0]    w_head_raddr;
    logic [CMD_LINES_W-1:0]  w_head_lines;

    always_comb begin
        w_full    = (count_q == (C_PTR_W+1)'(DEPTH));
        w_push    = cmd_valid && !w_full;
        w_push_ok = w_push && (cmd_line_num != '0);
        w_pop     = (state_q == S_FETCH);
        w_start   = (state_q == S_ISSUE) && ldst_done;
        w_chunk   = (rem_q > C_MAX_CHUNK) ? C_MAX_CHUNK : rem_q;
        {w_head_op, w_head_saddr, w_head_raddr, w_head_lines} = mem_q[rd_ptr_q];
    end

    assign cmd_ready        = !w_full;
    assign busy             = (state_q != S_IDLE) || (count_q != '0);
    assign err_zero_len     = err_q;
    assign q_count          = count_q;
    assign ldst_load_start  = w_start && !op_q;
    assign ldst_store_start = w_start && op_q;
    assign ldst_sdram_addr  = saddr_q;
    assign ldst_rf_addr     = raddr_q;
    assign ldst_line_num    = w_chunk[LINE_NUM_W-1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = w_push && (cmd_line_num == '0);
        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
        end
        if (w_push_ok && !w_pop) begin
            count_d = count_q + (C_PTR_W+1)'(1);
        end else if (!w_push_ok && w_pop) begin
            count_d = count_q - (C_PTR_W+1)'(1);
        end
    end

    // Working registers stay put from ISSUE through WAIT_DONE so the engine sees stable operands.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        saddr_d = saddr_q;
        raddr_d = raddr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                op_d    = w_head_op;
                saddr_d = w_head_saddr;
                raddr_d = w_head_raddr;
                rem_d   = w_head_lines;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (ldst_done) begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!ldst_done) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (ldst_done) begin
                    rem_d   = rem_q - w_chunk;
                    saddr_d = saddr_q + (32'(w_chunk) * 32'(LINE_BYTES));
                    raddr_d = raddr_q + w_chunk[RF_ADDR_W-1:0];
                    state_d = (rem_q == w_chunk) ? S_IDLE : S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            op_q     <= 1'b0;
            saddr_q  <= '0;
            raddr_q  <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            op_q     <= op_d;
            saddr_q  <= saddr_d;
            raddr_q  <= raddr_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_sdram_addr, cmd_rf_addr, cmd_line_num};
        end
    end

`ifdef LDST_SCHED_PERF_EN
    logic [31:0] perf_lines_q, perf_lines_d;
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [32:0] w_lines_sum;

    always_comb begin
        w_lines_sum  = {1'b0, perf_lines_q} + 33'(w_chunk);
        perf_lines_d = perf_lines_q;
        perf_busy_d  = perf_busy_q;
        if (w_start) begin
            perf_lines_d = w_lines_sum[32] ? '1 : w_lines_sum[31:0];
        end
        if (busy && (perf_busy_q != '1)) begin
            perf_busy_d = perf_busy_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lines_q <= '0;
            perf_busy_q  <= '0;
        end else begin
            perf_lines_q <= perf_lines_d;
            perf_busy_q  <= perf_busy_d;
        end
    end

    assign perf_lines       = perf_lines_q;
    assign perf_busy_cycles = perf_busy_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ldst_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldst_cmd_sched
// Purpose  : Self-checking bench: engine model plus chunk-level scoreboard
//            for ldst_cmd_sched, directed cases then random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldst_cmd_sched;

    localparam int RF_ADDR_W   = 10;
    localparam int LINE_NUM_W  = 11;
    localparam int CMD_LINES_W = 16;
    localparam int DEPTH       = 4;
    localparam int LINE_BYTES  = 176;
    localparam int MAXC        = 2047;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_op;
    logic [31:0]            cmd_sdram_addr;
    logic [RF_ADDR_W-1:0]   cmd_rf_addr;
    logic [CMD_LINES_W-1:0] cmd_line_num;
    logic                   ldst_load_start;
    logic                   ldst_store_start;
    logic [31:0]            ldst_sdram_addr;
    logic [RF_ADDR_W-1:0]   ldst_rf_addr;
    logic [LINE_NUM_W-1:0]  ldst_line_num;
    logic                   ldst_done;
    logic                   busy;
    logic                   err_zero_len;
    logic [2:0]             q_count;
`ifdef LDST_SCHED_PERF_EN
    logic [31:0]            perf_lines;
    logic [31:0]            perf_busy_cycles;
`endif

    always #5 clk = ~clk;

    ldst_cmd_sched #(
        .RF_ADDR_W(RF_ADDR_W), .LINE_NUM_W(LINE_NUM_W), .CMD_LINES_W(CMD_LINES_W),
        .DEPTH(DEPTH), .LINE_BYTES(LINE_BYTES)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sdram_addr(cmd_sdram_addr), .cmd_rf_addr(cmd_rf_addr), .cmd_line_num(cmd_line_num),
        .ldst_load_start(ldst_load_start), .ldst_store_start(ldst_store_start),
        .ldst_sdram_addr(ldst_sdram_addr), .ldst_rf_addr(ldst_rf_addr),
        .ldst_line_num(ldst_line_num), .ldst_done(ldst_done),
        .busy(busy), .err_zero_len(err_zero_len),
`ifdef LDST_SCHED_PERF_EN
        .perf_lines(perf_lines), .perf_busy_cycles(perf_busy_cycles),
`endif
        .q_count(q_count)
    );

    typedef struct {
        bit        op;
        bit [31:0] sa;
        bit [9:0]  ra;
        int        n;
    } chunk_t;

    chunk_t exp_q[$];
    int n_vec = 0, n_bad = 0, cyc = 0;
    int eng_cnt = 0, lat = 2;
    bit hold_low = 0, holding = 0, prev_done = 1, exp_err = 0, chk_rst = 0;
    bit [31:0] h_sa;
    bit [9:0]  h_ra;
    bit [10:0] h_n;
    int rise_cyc = 0, start_cyc = 0, n_starts = 0, gap_chk = 0;
    int n_err_pulses = 0, acc_cnt = 0;
    longint sum_lines = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference: break a command into the chunk sequence the engine must see.
    task automatic expand(input bit op, input bit [31:0] sa, input bit [9:0] ra, input int n);
        chunk_t c;
        while (n > 0) begin
            c.op = op;
            c.n  = (n > MAXC) ? MAXC : n;
            c.sa = sa;
            c.ra = ra;
            exp_q.push_back(c);
            sa = sa + 32'(c.n * LINE_BYTES);
            ra = ra + 10'(c.n);
            n  = n - c.n;
        end
    endtask

    task automatic tick();
        chunk_t c;
        bit st;
        ldst_done = (eng_cnt == 0) && !hold_low;
        @(negedge clk);
        st = ldst_load_start | ldst_store_start;
        if (ldst_done && !prev_done) rise_cyc = cyc;
        prev_done = ldst_done;
        check("err_zero_len", err_zero_len, exp_err);
        if (err_zero_len) n_err_pulses++;
        if (chk_rst) begin
            chk_rst = 0;
            check("rst_ready", cmd_ready, 1);
            check("rst_busy", busy, 0);
            check("rst_q_count", q_count, 0);
            check("rst_load_start", ldst_load_start, 0);
            check("rst_store_start", ldst_store_start, 0);
            check("rst_sdram_addr", ldst_sdram_addr, 0);
            check("rst_rf_addr", ldst_rf_addr, 0);
            check("rst_line_num", ldst_line_num, 0);
`ifdef LDST_SCHED_PERF_EN
            check("rst_perf_lines", perf_lines, 0);
            check("rst_perf_busy", perf_busy_cycles, 0);
`endif
        end
        if (holding) begin
            check("hold_sdram_addr", ldst_sdram_addr, h_sa);
            check("hold_rf_addr", ldst_rf_addr, h_ra);
            check("hold_line_num", ldst_line_num, h_n);
        end
        if (st) begin
            n_starts++;
            start_cyc = cyc;
            check("both_starts", ldst_load_start & ldst_store_start, 0);
            check("done_at_start", ldst_done, 1);
            if (gap_chk != 0) check("start_gap", cyc - rise_cyc, gap_chk);
            if (exp_q.size() == 0) begin
                check("unexpected_start", 1, 0);
            end else begin
                c = exp_q.pop_front();
                check("chunk_op", ldst_store_start, c.op);
                check("chunk_sdram_addr", ldst_sdram_addr, c.sa);
                check("chunk_rf_addr", ldst_rf_addr, c.ra);
                check("chunk_line_num", ldst_line_num, c.n);
                sum_lines += c.n;
            end
            holding = 1;
            h_sa = ldst_sdram_addr;
            h_ra = ldst_rf_addr;
            h_n  = ldst_line_num;
            eng_cnt = lat;
        end else begin
            if (eng_cnt > 0) eng_cnt--;
            if (holding && ldst_done) holding = 0;
        end
        exp_err = 0;
        if (rst) begin
            exp_q.delete();
            holding = 0;
            sum_lines = 0;
        end else if (cmd_valid && cmd_ready) begin
            acc_cnt++;
            if (cmd_line_num == 0) exp_err = 1;
            else expand(cmd_op, cmd_sdram_addr, cmd_rf_addr, int'(cmd_line_num));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push_cmd(input bit op, input bit [31:0] sa, input bit [9:0] ra,
                            input int n, output int t);
        int a, b;
        cmd_valid = 1; cmd_op = op; cmd_sdram_addr = sa; cmd_rf_addr = ra;
        cmd_line_num = 16'(n);
        a = acc_cnt; b = 200; t = -1;
        while (acc_cnt == a && b > 0) begin
            t = cyc;
            tick();
            b--;
        end
        cmd_valid = 0;
        if (acc_cnt == a) check("push_timeout", 0, 1);
    endtask

    task automatic wait_starts(input int target, input int budget);
        while (n_starts < target && budget > 0) begin
            tick();
            budget--;
        end
        if (n_starts < target) check("start_timeout", n_starts, target);
    endtask

    task automatic wait_idle(input int budget);
        while (busy && budget > 0) begin
            tick();
            budget--;
        end
        check("idle_timeout", busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, s0, e0, k, a, b, rc;
        rst = 1; cmd_valid = 0; cmd_op = 0; cmd_sdram_addr = '0; cmd_rf_addr = '0;
        cmd_line_num = '0; ldst_done = 1;
        run(3);
        rst = 0; chk_rst = 1;
        run(2);

        // Single load, checking start latency and busy release.
        push_cmd(0, 32'h1000, 10'd5, 3, t);
        wait_starts(1, 20);
        check("load_latency", start_cyc - t, 3);
        wait_idle(50);
        check("busy_fall", cyc - rise_cyc, 1);

        // Long store split into three chunks, one cycle between chunks.
        s0 = n_starts;
        push_cmd(1, 32'h2000, 10'd1023, 4096, t);
        wait_starts(s0 + 1, 20);
        check("store_latency", start_cyc - t, 3);
        gap_chk = 1;
        wait_starts(s0 + 3, 100);
        gap_chk = 0;
        wait_idle(50);
        check("store_sb_empty", exp_q.size(), 0);

        // Zero-length command is dropped with a single error pulse.
        s0 = n_starts; e0 = n_err_pulses;
        push_cmd(0, 32'h3000, 10'd7, 0, t);
        tick();
        check("zero_q_count", q_count, 0);
        run(5);
        check("zero_err_once", n_err_pulses - e0, 1);
        check("zero_no_start", n_starts - s0, 0);
        check("zero_busy", busy, 0);

        // Engine held busy: start gated, FIFO fills to DEPTH.
        hold_low = 1;
        s0 = n_starts;
        push_cmd(0, 32'h4000, 10'd0, 2, t);
        run(5);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_valid = 1; cmd_op = k[0]; cmd_sdram_addr = 32'h5000 + 32'(k) * 32'h100;
            cmd_rf_addr = 10'(k * 3); cmd_line_num = 16'(k + 1);
            a = acc_cnt;
            tick();
            if (acc_cnt != a) k++;
        end
        check("full_accepts", k, 4);
        check("full_q_count", q_count, 4);
        check("full_ready", cmd_ready, 0);
        check("gate_no_start", n_starts - s0, 0);
        hold_low = 0;
        rc = cyc;
        wait_starts(s0 + 1, 5);
        check("gate_release", start_cyc - rc, 0);
        gap_chk = 3;
        b = 200;
        while (k < 5 && b > 0) begin
            a = acc_cnt;
            tick();
            if (acc_cnt != a) k++;
            b--;
        end
        cmd_valid = 0;
        check("fifth_accepted", k, 5);
        wait_idle(500);
        gap_chk = 0;
        check("full_sb_empty", exp_q.size(), 0);

        // Reset while waiting on the engine with two commands queued.
        lat = 20;
        s0 = n_starts;
        push_cmd(0, 32'h8000, 10'd9, 3, t);
        wait_starts(s0 + 1, 20);
        push_cmd(1, 32'h9000, 10'd1, 4, t);
        push_cmd(0, 32'hA000, 10'd2, 5, t);
        run(2);
        check("pre_rst_q_count", q_count, 2);
        rst = 1;
        tick();
        rst = 0; chk_rst = 1;
        s0 = n_starts;
        run(40);
        check("no_start_after_rst", n_starts - s0, 0);
        check("post_rst_busy", busy, 0);
        lat = 2;

        // Random traffic against the chunk scoreboard.
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(1, 4);
            if (!cmd_valid && $urandom_range(0, 9) < 6) begin
                int r;
                r = $urandom_range(0, 9);
                cmd_valid = 1;
                cmd_op = 1'($urandom_range(0, 1));
                cmd_sdram_addr = $urandom;
                cmd_rf_addr = 10'($urandom_range(0, 1023));
                if (r == 0)      cmd_line_num = 16'd0;
                else if (r < 6)  cmd_line_num = 16'($urandom_range(1, 8));
                else if (r < 8)  cmd_line_num = 16'($urandom_range(2040, 2100));
                else             cmd_line_num = 16'($urandom_range(1, 6000));
            end
            a = acc_cnt;
            tick();
            if (acc_cnt != a) cmd_valid = 0;
        end
        cmd_valid = 0;
        wait_idle(4000);
        check("rand_sb_empty", exp_q.size(), 0);
        check("rand_q_count", q_count, 0);
`ifdef LDST_SCHED_PERF_EN
        check("perf_lines", perf_lines, 64'(sum_lines));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
